segre_wb_arbiter: RTL and testbench

Register-file write-port arbiter sitting between the EX, MEM and RVM pipeline tails and the single register-file write port. Each pipeline pushes completed results into its own small buffer. Each cycle, the arbiter grants the oldest pending result, ordered by history-file instruction id relative to the history-file head, and drives one registered write. It back-pressures pipelines whose buffer is full and reports pending writes to the decode hazard logic.

---
 rtl/segre_pkg.sv | 35 +++
 rtl/segre_wb_fifo.sv | 64 ++++++
 rtl/segre_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_segre_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// -----------------------------------------------------------------------------
// segre_pkg
// Shared types and constants for the writeback path of the segre core.
//   wb_src_e  : identity of a requesting pipeline tail (EX, MEM, RVM)
//   wb_req_t  : one buffered register-file write {waddr, data, instr_id}
//   wb_age()  : distance of an instruction id from the history-file head
// -----------------------------------------------------------------------------
package segre_pkg;

  localparam int WB_WORD_SIZE = 32;
  localparam int WB_REG_SIZE  = 5;
  localparam int WB_HF_PTR    = 4;
  localparam int WB_N_SRC     = 3;
  localparam int WB_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_SRC_EX  = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_RVM = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [WB_REG_SIZE-1:0]  waddr;
    logic [WB_WORD_SIZE-1:0] data;
    logic [WB_HF_PTR-1:0]    instr_id;
  } wb_req_t;

  // Ids wrap around the history file, so age is the modular distance from
  // the head: the oldest uncommitted instruction has age 0.
  function automatic logic [WB_HF_PTR-1:0] wb_age(input logic [WB_HF_PTR-1:0] id,
                                                   input logic [WB_HF_PTR-1:0] head);
    return id - head;
  endfunction

endpackage

// File: rtl/segre_wb_fifo.sv
// -----------------------------------------------------------------------------
// segre_wb_fifo
// Small per-source FIFO of pending register-file writes.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        drop all entries; a push in the same cycle is ignored
//   push_i/din_i   enqueue din_i (ignored while full)
//   pop_i          dequeue the head (ignored while empty)
//   head_o         current head entry, valid whenever count_o != 0
//   count_o        number of stored entries (registered)
// -----------------------------------------------------------------------------
module segre_wb_fifo
  import segre_pkg::*;
#(
  parameter int DEPTH = WB_BUF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  wb_req_t          din_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !flush_i && (cnt_reg != CNT_W'(DEPTH));
  assign do_pop  = pop_i  && !flush_i && (cnt_reg != '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      cnt_reg <= cnt_reg + 1'b1;
      else if (do_pop && !do_push) cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Storage needs no reset: stale slots are never visible while count is 0.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= din_i;
  end

  // The head must be visible in the cycle after the push so it can compete
  // for the grant, hence the asynchronous read of this tiny array.
  assign head_o  = mem[rd_ptr_reg];
  assign count_o = cnt_reg;

endmodule

// File: rtl/segre_wb_arbiter.sv
// -----------------------------------------------------------------------------
// segre_wb_arbiter
// Arbitrates the EX, MEM and RVM pipeline tails onto the single register-file
// write port. Each source owns a segre_wb_fifo; every cycle the oldest head
// (by history-file id relative to hf_head_i) is popped and registered onto
// the write port.
// Ports:
//   clk_i, rst_i, flush_i          clock, sync active-high reset, flush
//   hf_head_i                      id of oldest uncommitted instruction
//   src_valid_i/src_ready_o        per-source push handshake
//   src_waddr_i/data_i/instr_id_i  per-source packed result fields
//   rf_we_o/waddr_o/wdata_o        registered register-file write
//   rf_instr_id_o, rf_src_o        id and source of the written result
//   wb_pending_o                   any write buffered or in flight
//   conflict_cnt_o, stall_cnt_o    only when SEGRE_WB_PERF_EN is defined
// The field widths must match the segre_pkg constants (wb_req_t layout).
// -----------------------------------------------------------------------------
module segre_wb_arbiter
  import segre_pkg::*;
#(
  parameter int WORD_SIZE = WB_WORD_SIZE,
  parameter int REG_SIZE  = WB_REG_SIZE,
  parameter int HF_PTR    = WB_HF_PTR,
  parameter int N_SRC     = WB_N_SRC,
  parameter int BUF_DEPTH = WB_BUF_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [HF_PTR-1:0]         hf_head_i,
  input  logic [N_SRC-1:0]          src_valid_i,
  output logic [N_SRC-1:0]          src_ready_o,
  input  logic [N_SRC*REG_SIZE-1:0] src_waddr_i,
  input  logic [N_SRC*WORD_SIZE-1:0] src_data_i,
  input  logic [N_SRC*HF_PTR-1:0]   src_instr_id_i,
  output logic                      rf_we_o,
  output logic [REG_SIZE-1:0]       rf_waddr_o,
  output logic [WORD_SIZE-1:0]      rf_wdata_o,
  output logic [HF_PTR-1:0]         rf_instr_id_o,
  output logic [1:0]                rf_src_o,
  output logic                      wb_pending_o
`ifdef SEGRE_WB_PERF_EN
  ,
  output logic [31:0]               conflict_cnt_o,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  wb_req_t          push_req [N_SRC];
  wb_req_t          head_req [N_SRC];
  logic [CNT_W-1:0] count    [N_SRC];
  logic [N_SRC-1:0] push_en;
  logic [N_SRC-1:0] pop_en;
  logic [N_SRC-1:0] nonempty;

  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [HF_PTR-1:0] best_age;
  logic [HF_PTR-1:0] cur_age;
  wb_req_t          win_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign push_req[gi] = '{waddr:    src_waddr_i[gi*REG_SIZE +: REG_SIZE],
                              data:     src_data_i[gi*WORD_SIZE +: WORD_SIZE],
                              instr_id: src_instr_id_i[gi*HF_PTR +: HF_PTR]};

      // Ready depends only on registered occupancy, never on this cycle's pop.
      assign src_ready_o[gi] = (count[gi] < CNT_W'(BUF_DEPTH));
      assign nonempty[gi]    = (count[gi] != '0);

      // x0 writes complete the handshake but are never stored.
      assign push_en[gi] = src_valid_i[gi] && src_ready_o[gi] &&
                           (push_req[gi].waddr != '0);
      assign pop_en[gi]  = grant_valid && (grant_idx == 2'(gi));

      segre_wb_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push_en[gi]),
        .din_i   (push_req[gi]),
        .pop_i   (pop_en[gi]),
        .head_o  (head_req[gi]),
        .count_o (count[gi])
      );
    end
  endgenerate

  // Oldest head wins; the strict compare leaves ties with the lowest index.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    best_age    = '0;
    cur_age     = '0;
    win_req     = '0;
    for (int s = 0; s < N_SRC; s++) begin
      cur_age = wb_age(head_req[s].instr_id, hf_head_i);
      if (nonempty[s] && (!grant_valid || (cur_age < best_age))) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(s);
        best_age    = cur_age;
        win_req     = head_req[s];
      end
    end
  end

  // Address/data/id/src hold their last values when no write is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= '0;
      rf_wdata_o    <= '0;
      rf_instr_id_o <= '0;
      rf_src_o      <= WB_SRC_EX;
    end else if (flush_i) begin
      rf_we_o <= 1'b0;
    end else begin
      rf_we_o <= grant_valid;
      if (grant_valid) begin
        rf_waddr_o    <= win_req.waddr;
        rf_wdata_o    <= win_req.data;
        rf_instr_id_o <= win_req.instr_id;
        rf_src_o      <= grant_idx;
      end
    end
  end

  assign wb_pending_o = (|nonempty) || rf_we_o;

`ifdef SEGRE_WB_PERF_EN
  logic conflict_now;
  logic stall_now;

  // At least two bits set: clearing the lowest set bit leaves something.
  assign conflict_now = ((nonempty & (nonempty - 1'b1)) != '0);
  assign stall_now    = |(src_valid_i & ~src_ready_o);

  // Counters survive flush; only reset clears them. They saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (conflict_now && (conflict_cnt_o != '1)) conflict_cnt_o <= conflict_cnt_o + 1'b1;
      if (stall_now && (stall_cnt_o != '1))       stall_cnt_o    <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_segre_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_segre_wb_arbiter
// Randomized and directed stimulus against a queue-based reference model of
// the writeback arbiter. Define SEGRE_WB_PERF_EN to include the counters.
// -----------------------------------------------------------------------------
module tb_segre_wb_arbiter;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [3:0]  hf_head_i;
  logic [2:0]  src_valid_i;
  logic [2:0]  src_ready_o;
  logic [14:0] src_waddr_i;
  logic [95:0] src_data_i;
  logic [11:0] src_instr_id_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [3:0]  rf_instr_id_o;
  logic [1:0]  rf_src_o;
  logic        wb_pending_o;
`ifdef SEGRE_WB_PERF_EN
  logic [31:0] conflict_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  segre_wb_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .hf_head_i      (hf_head_i),
    .src_valid_i    (src_valid_i),
    .src_ready_o    (src_ready_o),
    .src_waddr_i    (src_waddr_i),
    .src_data_i     (src_data_i),
    .src_instr_id_i (src_instr_id_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .rf_instr_id_o  (rf_instr_id_o),
    .rf_src_o       (rf_src_o),
    .wb_pending_o   (wb_pending_o)
`ifdef SEGRE_WB_PERF_EN
    ,
    .conflict_cnt_o (conflict_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  id;
  } ent_t;

  // Reference model state: one queue of pending results per source.
  ent_t        q [3][$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [3:0]  exp_id;
  logic [1:0]  exp_src;
  int unsigned exp_conf;
  int unsigned exp_stall;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic [2:0] v, input logic [14:0] wa, input logic [95:0] dd,
                      input logic [11:0] ids, input logic [3:0] hd, input logic fl,
                      input logic rs);
    logic [2:0] acc;
    int         best;
    int         bage;
    int         age;
    int         nne;
    ent_t       e;
    rst_i          = rs;
    flush_i        = fl;
    hf_head_i      = hd;
    src_valid_i    = v;
    src_waddr_i    = wa;
    src_data_i     = dd;
    src_instr_id_i = ids;

    if (rs) begin
      for (int s = 0; s < 3; s++) q[s].delete();
      exp_we = 0; exp_addr = 0; exp_data = 0; exp_id = 0; exp_src = 0;
      exp_conf = 0; exp_stall = 0;
    end else begin
      nne = 0;
      for (int s = 0; s < 3; s++) begin
        acc[s] = (q[s].size() < D);
        if (q[s].size() > 0) nne++;
      end
      if (nne >= 2) exp_conf++;
      if ((v & ~acc) != 3'b000) exp_stall++;
      if (fl) begin
        for (int s = 0; s < 3; s++) q[s].delete();
        exp_we = 0;
      end else begin
        best = -1;
        bage = 0;
        for (int s = 0; s < 3; s++) begin
          if (q[s].size() > 0) begin
            age = (int'(q[s][0].id) - int'(hd) + 16) % 16;
            if (best < 0 || age < bage) begin
              best = s;
              bage = age;
            end
          end
        end
        exp_we = (best >= 0);
        if (best >= 0) begin
          e = q[best].pop_front();
          exp_addr = e.a; exp_data = e.d; exp_id = e.id; exp_src = 2'(best);
        end
        for (int s = 0; s < 3; s++) begin
          if (v[s] && acc[s] && wa[s*5 +: 5] != 5'd0) begin
            e.a = wa[s*5 +: 5]; e.d = dd[s*32 +: 32]; e.id = ids[s*4 +: 4];
            q[s].push_back(e);
          end
        end
      end
    end

    @(posedge clk);
    #1;
    check("rf_we", rf_we_o, exp_we);
    check("rf_waddr", rf_waddr_o, exp_addr);
    check("rf_wdata", rf_wdata_o, exp_data);
    check("rf_instr_id", rf_instr_id_o, exp_id);
    check("rf_src", rf_src_o, exp_src);
    for (int s = 0; s < 3; s++)
      check($sformatf("src_ready%0d", s), src_ready_o[s], q[s].size() < D);
    check("wb_pending", wb_pending_o,
          (q[0].size() + q[1].size() + q[2].size() > 0) || exp_we);
`ifdef SEGRE_WB_PERF_EN
    check("conflict_cnt", conflict_cnt_o, exp_conf);
    check("stall_cnt", stall_cnt_o, exp_stall);
`endif
    if (rf_we_o)
      $display("WB src=%0d addr=%0d data=%08h id=%0d", rf_src_o, rf_waddr_o, rf_wdata_o, rf_instr_id_o);
  endtask

  task automatic idle(input logic [3:0] hd);
    step(3'b000, 15'd0, 96'd0, 12'd0, hd, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1; flush_i = 0; hf_head_i = 0; src_valid_i = 0;
    src_waddr_i = 0; src_data_i = 0; src_instr_id_i = 0;
    exp_we = 0; exp_addr = 0; exp_data = 0; exp_id = 0; exp_src = 0;
    exp_conf = 0; exp_stall = 0;

    // Reset
    step(3'b000, 15'd0, 96'd0, 12'd0, 4'd0, 1'b0, 1'b1);
    step(3'b000, 15'd0, 96'd0, 12'd0, 4'd0, 1'b0, 1'b1);
    check("rst_ready", {29'd0, src_ready_o}, 32'h7);
    check("rst_pending", wb_pending_o, 1'b0);

    // Single EX push: waddr 5, data DEADBEEF, id 3, head 0
    step(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, {8'd0, 4'd3}, 4'd0, 1'b0, 1'b0);
    check("tp1_lat1_we", rf_we_o, 1'b0);
    idle(4'd0);
    check("tp1_we", rf_we_o, 1'b1);
    check("tp1_addr", rf_waddr_o, 5'd5);
    check("tp1_data", rf_wdata_o, 32'hDEADBEEF);
    check("tp1_id", rf_instr_id_o, 4'd3);
    check("tp1_src", rf_src_o, 2'd0);
    idle(4'd0);
    check("tp1_we_off", rf_we_o, 1'b0);

    // Wrap-around age with head 14: EX id 1, MEM id 15, RVM id 14
    step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hC, 32'hB, 32'hA}, {4'd14, 4'd15, 4'd1},
         4'd14, 1'b0, 1'b0);
    idle(4'd14);
    check("tp2_first", rf_src_o, 2'd2);
    idle(4'd14);
    check("tp2_second", rf_src_o, 2'd1);
    idle(4'd14);
    check("tp2_third", rf_src_o, 2'd0);
    idle(4'd14);

    // MEM pushes every cycle while EX keeps offering an older id
    for (int i = 0; i < 6; i++)
      step(3'b011, {5'd0, 5'(20 + i), 5'd3}, {32'd0, 32'(100 + i), 32'(i)},
           {4'd0, 4'd5, 4'd1}, 4'd0, 1'b0, 1'b0);
    check("tp3_mem_full", src_ready_o[1], 1'b0);
    for (int i = 0; i < 4; i++) idle(4'd0);

    // x0 push is dropped
    step(3'b001, 15'd0, {64'd0, 32'h1234}, 12'd0, 4'd0, 1'b0, 1'b0);
    idle(4'd0);
    check("tp4_pending", wb_pending_o, 1'b0);
    check("tp4_we", rf_we_o, 1'b0);

    // Fill buffers, then flush with simultaneous pushes
    for (int i = 0; i < 3; i++)
      step(3'b111, {5'd7, 5'd8, 5'd9}, {32'h7, 32'h8, 32'h9}, {4'd2, 4'd3, 4'd4},
           4'd0, 1'b0, 1'b0);
    step(3'b111, {5'd7, 5'd8, 5'd9}, {32'h7, 32'h8, 32'h9}, {4'd2, 4'd3, 4'd4},
         4'd0, 1'b1, 1'b0);
    check("tp5_we", rf_we_o, 1'b0);
    check("tp5_ready", {29'd0, src_ready_o}, 32'h7);
    check("tp5_pending", wb_pending_o, 1'b0);

    // Randomized traffic, with occasional flushes, head moves and resets
    begin
      logic [3:0] hd;
      logic [14:0] wa;
      hd = 4'd0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 7) == 0) hd = 4'($urandom);
        wa = 15'($urandom);
        for (int s = 0; s < 3; s++)
          if ($urandom_range(0, 9) == 0) wa[s*5 +: 5] = 5'd0;
        step(3'($urandom), wa, {$urandom, $urandom, $urandom}, 12'($urandom), hd,
             $urandom_range(0, 63) == 0, $urandom_range(0, 299) == 0);
      end
    end

`ifdef SEGRE_WB_PERF_EN
    step(3'b000, 15'd0, 96'd0, 12'd0, 4'd0, 1'b0, 1'b1);
    check("perf_rst_conf", conflict_cnt_o, 32'd0);
    check("perf_rst_stall", stall_cnt_o, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
